// File: rtl/qspi_postcode_pkg.sv
// -----------------------------------------------------------------------------
// qspi_postcode_pkg
// Shared definitions for the host-side QSPI POST-code reader: the frame-engine
// state encoding, frame layout, overrun limit and the saturating counter helper.
// No ports (package).
// -----------------------------------------------------------------------------
package qspi_postcode_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int         NIBBLES_PER_FRAME = 4;
   localparam logic [7:0] OVERRUN_MAX       = 8'hFF;

   // One frame as it leaves the shift register: first byte is the port 0x80 code.
   typedef struct packed {
      logic [7:0] code_80;
      logic [7:0] code_81;
   } frame_t;

   // Increment that sticks at OVERRUN_MAX instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      logic [7:0] result;
      if (value == OVERRUN_MAX) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/qspi_postcode_reader_fifo.sv
// -----------------------------------------------------------------------------
// postcode_fifo
// Synchronous first-word-fall-through FIFO of frames, used as the code history
// when QSPI_POSTCODE_HISTORY_EN is defined. A push while full succeeds only if
// a pop happens in the same cycle.
// Ports:
//   clk, rst       clock and synchronous active-high reset (clears contents)
//   push, wr_data  write request and frame to store
//   pop            read request; ignored while empty
//   rd_data        head entry (valid while !empty)
//   full, empty    occupancy flags
// -----------------------------------------------------------------------------
module postcode_fifo
   import qspi_postcode_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  frame_t wr_data,
   input  logic   pop,
   output frame_t rd_data,
   output logic   full,
   output logic   empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   frame_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            wr_en;
   logic            rd_en;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == {(AW+1){1'b0}});
   assign rd_en   = pop && !empty;
   // A full FIFO can still accept a write when the head leaves in the same cycle.
   assign wr_en   = push && (!full || rd_en);
   assign rd_data = mem[rd_ptr];

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= frame_t'(16'h0000);
         end
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
            2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/qspi_postcode_reader.sv
// -----------------------------------------------------------------------------
// qspi_postcode_reader
// Host-side QSPI master for the LPC POST-code debug tool. On a rising edge of
// the (synchronized) interrupt it clocks in one 4-nibble frame, MSB first, and
// presents code_80/code_81 through a valid/ready handshake. Interrupts that
// arrive mid-frame collapse into one pending read.
// Build option: define QSPI_POSTCODE_HISTORY_EN to replace the single holding
// register with a FIFO_DEPTH-entry history FIFO (postcode_fifo).
// Ports:
//   host_clk, host_rst   clock and synchronous active-high reset
//   qspi_int             asynchronous new-code interrupt from the debug tool
//   qspi_in[3:0]         data nibble, stable while qspi_clk is high
//   qspi_clk             generated QSPI clock, idles low
//   busy                 frame in progress
//   code_valid/ready     output handshake
//   code_80, code_81     received codes
//   overrun_cnt          dropped frames, saturating at 255
// -----------------------------------------------------------------------------
module qspi_postcode_reader
   import qspi_postcode_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       host_clk,
   input  logic       host_rst,
   input  logic       qspi_int,
   input  logic [3:0] qspi_in,
   output logic       qspi_clk,
   output logic       busy,
   output logic       code_valid,
   input  logic       code_ready,
   output logic [7:0] code_80,
   output logic [7:0] code_81,
   output logic [7:0] overrun_cnt
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [1:0] NIB_LAST = 2'(NIBBLES_PER_FRAME - 1);

   logic       int_s1;
   logic       int_s2;
   logic       int_d;
   logic       int_rise;

   state_t     state;
   state_t     state_next;
   logic [7:0] div_cnt;
   logic [7:0] div_cnt_next;
   logic [1:0] nib_cnt;
   logic [1:0] nib_cnt_next;
   logic [15:0] shift;
   logic [15:0] shift_next;
   logic       pending;
   logic       pending_next;
   logic       qspi_clk_next;
   logic       busy_next;
   logic       frame_done;
   frame_t     done_frame;

   assign int_rise   = int_s2 && !int_d;
   assign frame_done = (state == DONE);
   assign done_frame = frame_t'(shift);

   // Two-stage synchronizer plus the delayed copy used for edge detection.
   always_ff @(posedge host_clk) begin
      if (host_rst) begin
         int_s1 <= 1'b0;
         int_s2 <= 1'b0;
         int_d  <= 1'b0;
      end else begin
         int_s1 <= qspi_int;
         int_s2 <= int_s1;
         int_d  <= int_s2;
      end
   end

   // Frame engine state and the registered qspi_clk/busy outputs.
   always_ff @(posedge host_clk) begin
      if (host_rst) begin
         state    <= IDLE;
         div_cnt  <= 8'd0;
         nib_cnt  <= 2'd0;
         shift    <= 16'h0000;
         pending  <= 1'b0;
         qspi_clk <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         div_cnt  <= div_cnt_next;
         nib_cnt  <= nib_cnt_next;
         shift    <= shift_next;
         pending  <= pending_next;
         qspi_clk <= qspi_clk_next;
         busy     <= busy_next;
      end
   end

   // Next-state logic for the frame engine.
   always_comb begin
      state_next   = state;
      div_cnt_next = div_cnt;
      nib_cnt_next = nib_cnt;
      shift_next   = shift;
      // An edge seen while a frame runs is remembered; repeats collapse into it.
      pending_next = pending || int_rise;

      case (state)
         IDLE: begin
            if (int_rise || pending) begin
               state_next   = LOW;
               div_cnt_next = 8'd0;
               nib_cnt_next = 2'd0;
               pending_next = 1'b0;
            end else begin
               state_next   = IDLE;
            end
         end
         LOW: begin
            if (div_cnt == DIV_LAST) begin
               state_next   = HIGH;
               div_cnt_next = 8'd0;
            end else begin
               div_cnt_next = div_cnt + 8'd1;
            end
         end
         HIGH: begin
            if (div_cnt == DIV_LAST) begin
               // Sample just before qspi_clk falls; the slave changes data on the fall.
               shift_next   = {shift[11:0], qspi_in};
               nib_cnt_next = nib_cnt + 2'd1;
               div_cnt_next = 8'd0;
               if (nib_cnt == NIB_LAST) begin
                  state_next = DONE;
               end else begin
                  state_next = LOW;
               end
            end else begin
               div_cnt_next = div_cnt + 8'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      qspi_clk_next = (state_next == HIGH);
      busy_next     = (state_next != IDLE);
   end

`ifdef QSPI_POSTCODE_HISTORY_EN

   logic   fifo_full;
   logic   fifo_empty;
   logic   fifo_push;
   logic   fifo_pop;
   frame_t head;

   assign fifo_pop   = !fifo_empty && code_ready;
   assign fifo_push  = frame_done;
   assign code_valid = !fifo_empty;
   assign code_80    = head.code_80;
   assign code_81    = head.code_81;

   postcode_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (host_clk),
      .rst     (host_rst),
      .push    (fifo_push),
      .wr_data (done_frame),
      .pop     (fifo_pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Count frames lost because the history is full and nothing leaves this cycle.
   always_ff @(posedge host_clk) begin
      if (host_rst) begin
         overrun_cnt <= 8'd0;
      end else if (frame_done && fifo_full && !fifo_pop) begin
         overrun_cnt <= sat_inc(overrun_cnt);
      end
   end

`else

   // Single holding register: a new frame replaces the old one only once it is read.
   always_ff @(posedge host_clk) begin
      if (host_rst) begin
         code_valid  <= 1'b0;
         code_80     <= 8'd0;
         code_81     <= 8'd0;
         overrun_cnt <= 8'd0;
      end else if (frame_done) begin
         if (!code_valid || code_ready) begin
            code_80    <= done_frame.code_80;
            code_81    <= done_frame.code_81;
            code_valid <= 1'b1;
         end else begin
            overrun_cnt <= sat_inc(overrun_cnt);
         end
      end else if (code_valid && code_ready) begin
         code_valid <= 1'b0;
      end
   end

`endif

endmodule

// File: doc/qspi_postcode_reader.md
# qspi_postcode_reader

Host-side QSPI master for the LPC POST-code debug tool. It sits on the display/host board at the far end of the QSPI link. When the debug tool raises its interrupt, the block clocks out one frame carrying the port 0x80 and 0x81 codes and reassembles the two bytes. It then presents them to downstream logic through a valid/ready handshake.

## Interface
Parameters:
- CLK_DIV, 4: QSPI half-period in host_clk cycles; legal range 2..255.
- FIFO_DEPTH, 8: history depth; power of two; used only when history is compiled in.

Ports:
- host_clk  in  1  block clock; single clock domain.
- host_rst  in  1  synchronous, active-high reset.
- qspi_int  in  1  new-code interrupt from the debug tool; asynchronous; passed through a 2-FF synchronizer.
- qspi_in  in  4  data nibble from the debug tool; stable while qspi_clk is high.
- qspi_clk  out  1  QSPI clock generated by this block; idles low.
- busy  out  1  high while a frame is in progress.
- code_valid  out  1  code_80/code_81 hold an unread frame.
- code_ready  in  1  consumer accepts the frame when code_valid && code_ready.
- code_80  out  8  port 0x80 code.
- code_81  out  8  port 0x81 code.
- overrun_cnt  out  8  count of dropped frames; saturates at 255.

## Operation
- Frame format: 4 nibbles, MSB first, in this order: code_80[7:4], code_80[3:0], code_81[7:4], code_81[3:0].
- The slave updates qspi_in on the falling edge of qspi_clk.
- Synchronizer path: qspi_int → int_s1 → int_s2. A rising edge is detected as int_s2 && !int_d.
- State machine:
  - IDLE: qspi_clk=0, busy=0. A rising int edge, or a pending flag, moves to LOW, clears the nibble counter and clears pending.
  - LOW: qspi_clk=0 for CLK_DIV cycles, then go to HIGH.
  - HIGH: qspi_clk=1 for CLK_DIV cycles. On the last cycle, shift qspi_in into the 16-bit shift register and increment the 2-bit nibble counter. Go to LOW if the counter was < 3, otherwise go to DONE.
  - DONE: one cycle with qspi_clk=0. Deliver the shift register to the output stage, then return to IDLE.
- A rising int edge while busy sets a pending flag. Multiple edges collapse into one pending read.
- Output stage (history not compiled in): a single holding register.
  - On DONE with !code_valid, or with code_valid && code_ready in the same cycle: load the register and keep code_valid=1.
  - On DONE with code_valid && !code_ready: drop the new frame and increment overrun_cnt. The held frame is kept.
  - On a handshake with no DONE: code_valid → 0.
- overrun_cnt saturates at 255 and never wraps. Only reset clears it.

## Timing
- Reset values: qspi_clk=0, busy=0, code_valid=0, code_80=0, code_81=0, overrun_cnt=0. Reset also clears the FSM (to IDLE), synchronizer, pending flag, shift register and FIFO.
- Reset mid-frame aborts the frame. qspi_clk is low on the first cycle after reset and the partial data is discarded.
- Start latency: the FSM enters LOW 3 host_clk cycles after qspi_int is first sampled high.
- First qspi_clk rising edge occurs CLK_DIV cycles after entry to LOW.
- Frame length: 8·CLK_DIV cycles from LOW entry to DONE.
- code_valid rises on the cycle after DONE.
- A pending read re-enters LOW on the cycle after IDLE is reached, giving a one-cycle IDLE gap between frames.

## Configuration
- QSPI_POSTCODE_HISTORY_EN defined:
  - The holding register is replaced by a FIFO_DEPTH-entry FIFO. code_valid means the FIFO is not empty, and code_80/code_81 show the head entry (first-word fall-through).
  - DONE with the FIFO full drops the frame and increments overrun_cnt.
  - A pop and a push in the same cycle while full both succeed.
- Not defined: single holding register as described in Operation.

## Structure
- Shared package qspi_postcode_pkg contains:
  - FSM state enum: IDLE, LOW, HIGH, DONE.
  - NIBBLES_PER_FRAME = 4.
  - OVERRUN_MAX = 8'hFF.
  - Frame typedef: {code_80, code_81}.
- Sub-module postcode_fifo: synchronous FIFO, 16-bit wide, FIFO_DEPTH deep, with full/empty outputs. Instantiated only under QSPI_POSTCODE_HISTORY_EN.

## Test plan
- Reset, then a qspi_int pulse with a slave model serving 0xA5/0x3C at CLK_DIV=4 → qspi_clk shows 4 pulses of 8 cycles each; code_80=0xA5, code_81=0x3C; code_valid rises 36 cycles after the int edge.
- Two int edges 10 cycles apart → one pending read follows the first frame after a one-cycle IDLE gap; two frames are delivered.
- code_ready held low while 3 frames arrive (history off) → first frame is retained; overrun_cnt=2.
- host_rst asserted after nibble 2 → qspi_clk is low on the next cycle; code_valid stays 0; the next int produces a clean frame.
- History on, 9 frames with ready low → 8 entries are popped in order; overrun_cnt=1.
- 300 dropped frames → overrun_cnt saturates at 255.
